// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx stream input among NUM_REQ sources.
// A grant lasts until the grantee's last word or MAX_BURST transfers, then re-arbitrates in IDLE.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned BITS_PER_WORD = 8,
   parameter int unsigned MAX_BURST     = 16,
   localparam int unsigned IdW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int unsigned CntW         = $clog2(MAX_BURST + 1)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*BITS_PER_WORD-1:0]   req_data,
   input  logic [NUM_REQ-1:0]                 req_last,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               s_valid,
   output logic [BITS_PER_WORD-1:0]           s_data,
   input  logic                               s_ready,
   output logic [IdW-1:0]                     grant_id,
   output logic                               busy
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e              state_q;
   logic [IdW-1:0]      grant_id_q;
   logic [IdW-1:0]      rr_ptr_q;
   logic [CntW-1:0]     word_cnt_q;

   logic                any_req;
   logic [IdW-1:0]      winner;
   logic [IdW-1:0]      cand;

   logic                in_busy;
   logic                g_valid;
   logic                g_last;
   logic [BITS_PER_WORD-1:0] g_data;
   logic                xfer;
   logic                burst_end;
   logic                pkt_end;

   // Search starts just after the last grantee, so the previous winner has lowest priority.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      cand    = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         cand = IdW'((32'(rr_ptr_q) + unsigned'(k)) % NUM_REQ);
         if (!any_req && req_valid[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

   // Select the granted source's signals.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (IdW'(i) == grant_id_q) begin
            g_valid = req_valid[i];
            g_last  = req_last[i];
            g_data  = req_data[i*BITS_PER_WORD +: BITS_PER_WORD];
         end
      end
   end

   assign in_busy = (state_q == StBusy);

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         req_ready[i] = in_busy && (IdW'(i) == grant_id_q) && s_ready;
      end
   end

   assign s_valid   = in_busy && g_valid;
   assign s_data    = in_busy ? g_data : '0;
   assign xfer      = s_valid && s_ready;
   assign burst_end = (32'(word_cnt_q) + 32'd1) == MAX_BURST;
   assign pkt_end   = xfer && (g_last || burst_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         grant_id_q <= '0;
         rr_ptr_q   <= IdW'(NUM_REQ - 1);
         word_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  grant_id_q <= winner;
                  word_cnt_q <= '0;
                  state_q    <= StBusy;
               end
            end
            StBusy: begin
               if (xfer) begin
                  word_cnt_q <= word_cnt_q + CntW'(1);
                  if (pkt_end) begin
                     rr_ptr_q <= grant_id_q;
                     state_q  <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = in_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single source, contention, burst cap,
// backpressure, round-robin fairness and reset in the middle of a packet.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic [1:0]  grant_id;
   logic        busy;

   int checks;
   int failures;

   uart_tx_arbiter #(
      .NUM_REQ       (4),
      .BITS_PER_WORD (8),
      .MAX_BURST     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic l);
      req_valid[i]       = v;
      req_data[i*8 +: 8] = d;
      req_last[i]        = l;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      s_ready   = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_data  = 32'hDEADBEEF;
      req_last  = 4'b1111;
      s_ready   = 1'b1;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin failures++;
         $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (s_valid !== 1'b0) begin failures++;
         $display("FAIL reset_s_valid got=%0b exp=0", s_valid); end
      checks++; if (s_data !== 8'h00) begin failures++;
         $display("FAIL reset_s_data got=%h exp=00", s_data); end
      checks++; if (req_ready !== 4'b0000) begin failures++;
         $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      checks++; if (grant_id !== 2'd0) begin failures++;
         $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
      checks++; if (dut.rr_ptr_q !== 2'd3) begin failures++;
         $display("FAIL reset_rr_ptr got=%0d exp=3", dut.rr_ptr_q); end
      checks++; if (dut.word_cnt_q !== 5'd0) begin failures++;
         $display("FAIL reset_word_cnt got=%0d exp=0", dut.word_cnt_q); end
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      rst       = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      set_src(2, 1'b1, 8'h41, 1'b0);
      #1;
      checks++; if (busy !== 1'b0 || s_valid !== 1'b0) begin failures++;
         $display("FAIL single_idle busy=%0b s_valid=%0b exp=0,0", busy, s_valid); end
      tick();
      for (int w = 0; w < 3; w++) begin
         set_src(2, 1'b1, 8'(8'h41 + w), (w == 2));
         #1;
         checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin failures++;
            $display("FAIL single_grant w=%0d busy=%0b grant=%0d exp=1,2", w, busy, grant_id); end
         checks++; if (s_valid !== 1'b1 || s_data !== 8'(8'h41 + w)) begin failures++;
            $display("FAIL single_data w=%0d got=%0b/%h exp=1/%h", w, s_valid, s_data,
                     8'(8'h41 + w)); end
         checks++; if (req_ready !== 4'b0100) begin failures++;
            $display("FAIL single_ready w=%0d got=%b exp=0100", w, req_ready); end
         tick();
      end
      set_src(2, 1'b0, 8'h00, 1'b0);
      #1;
      checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd2 || grant_id !== 2'd2) begin
         failures++;
         $display("FAIL single_end busy=%0b rr=%0d grant=%0d exp=0,2,2", busy, dut.rr_ptr_q,
                  grant_id); end
   endtask

   task automatic test_contention();
      apply_reset();
      set_src(0, 1'b1, 8'hA0, 1'b0);
      set_src(1, 1'b1, 8'hB0, 1'b0);
      tick();
      for (int w = 0; w < 2; w++) begin
         set_src(0, 1'b1, 8'(8'hA0 + w), (w == 1));
         #1;
         checks++; if (grant_id !== 2'd0 || s_data !== 8'(8'hA0 + w)) begin failures++;
            $display("FAIL cont_src0 w=%0d grant=%0d data=%h exp=0/%h", w, grant_id, s_data,
                     8'(8'hA0 + w)); end
         checks++; if (req_ready !== 4'b0001) begin failures++;
            $display("FAIL cont_ready0 w=%0d got=%b exp=0001", w, req_ready); end
         tick();
      end
      set_src(0, 1'b0, 8'h00, 1'b0);
      #1;
      checks++; if (busy !== 1'b0 || s_valid !== 1'b0 || req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL cont_gap busy=%0b s_valid=%0b ready=%b exp=0,0,0000", busy, s_valid,
                  req_ready); end
      tick();
      for (int w = 0; w < 2; w++) begin
         set_src(1, 1'b1, 8'(8'hB0 + w), (w == 1));
         #1;
         checks++; if (grant_id !== 2'd1 || s_data !== 8'(8'hB0 + w)) begin failures++;
            $display("FAIL cont_src1 w=%0d grant=%0d data=%h exp=1/%h", w, grant_id, s_data,
                     8'(8'hB0 + w)); end
         checks++; if (req_ready !== 4'b0010) begin failures++;
            $display("FAIL cont_ready1 w=%0d got=%b exp=0010", w, req_ready); end
         tick();
      end
      set_src(1, 1'b0, 8'h00, 1'b0);
      #1;
      checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin failures++;
         $display("FAIL cont_end busy=%0b rr=%0d exp=0,1", busy, dut.rr_ptr_q); end
   endtask

   task automatic test_burst_cap();
      apply_reset();
      set_src(3, 1'b1, 8'h30, 1'b0);
      tick();
      for (int n = 0; n < 16; n++) begin
         set_src(3, 1'b1, 8'(8'h30 + n), 1'b0);
         if (n == 0) set_src(0, 1'b1, 8'h0F, 1'b1);
         #1;
         checks++; if (grant_id !== 2'd3 || s_data !== 8'(8'h30 + n) || req_ready !== 4'b1000)
         begin failures++;
            $display("FAIL cap_first n=%0d grant=%0d data=%h ready=%b exp=3/%h/1000", n,
                     grant_id, s_data, req_ready, 8'(8'h30 + n)); end
         tick();
      end
      set_src(3, 1'b1, 8'h40, 1'b0);
      #1;
      checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd3) begin failures++;
         $display("FAIL cap_rotate busy=%0b rr=%0d exp=0,3", busy, dut.rr_ptr_q); end
      tick();
      checks++; if (grant_id !== 2'd0 || s_data !== 8'h0F || req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL cap_src0 grant=%0d data=%h ready=%b exp=0/0f/0001", grant_id, s_data,
                  req_ready); end
      tick();
      set_src(0, 1'b0, 8'h00, 1'b0);
      #1;
      checks++; if (busy !== 1'b0) begin failures++;
         $display("FAIL cap_gap busy=%0b exp=0", busy); end
      tick();
      for (int n = 16; n < 20; n++) begin
         set_src(3, 1'b1, 8'(8'h30 + n), (n == 19));
         #1;
         checks++; if (grant_id !== 2'd3 || s_data !== 8'(8'h30 + n) || s_valid !== 1'b1) begin
            failures++;
            $display("FAIL cap_rest n=%0d grant=%0d data=%h valid=%0b exp=3/%h/1", n, grant_id,
                     s_data, s_valid, 8'(8'h30 + n)); end
         tick();
      end
      set_src(3, 1'b0, 8'h00, 1'b0);
      #1;
      checks++; if (busy !== 1'b0) begin failures++;
         $display("FAIL cap_end busy=%0b exp=0", busy); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      s_ready = 1'b0;
      set_src(1, 1'b1, 8'h55, 1'b1);
      tick();
      for (int c = 0; c < 10; c++) begin
         checks++; if (s_valid !== 1'b1 || s_data !== 8'h55 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_hold c=%0d valid=%0b data=%h ready=%b exp=1/55/0000", c, s_valid,
                     s_data, req_ready); end
         checks++; if (dut.word_cnt_q !== 5'd0 || busy !== 1'b1) begin failures++;
            $display("FAIL bp_cnt c=%0d cnt=%0d busy=%0b exp=0,1", c, dut.word_cnt_q, busy); end
         tick();
      end
      s_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0010) begin failures++;
         $display("FAIL bp_release ready=%b exp=0010", req_ready); end
      tick();
      set_src(1, 1'b0, 8'h00, 1'b0);
      #1;
      checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin failures++;
         $display("FAIL bp_done busy=%0b rr=%0d exp=0,1", busy, dut.rr_ptr_q); end
   endtask

   task automatic test_fairness();
      apply_reset();
      for (int i = 0; i < 4; i++) set_src(i, 1'b1, 8'(8'hC0 + i), 1'b1);
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++; if (grant_id !== 2'(k % 4) || s_data !== 8'(8'hC0 + k % 4) ||
                       req_ready !== 4'(1 << (k % 4))) begin failures++;
            $display("FAIL fair k=%0d grant=%0d data=%h ready=%b exp=%0d", k, grant_id, s_data,
                     req_ready, k % 4); end
         tick();
         checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL fair_gap k=%0d busy=%0b exp=0", k, busy); end
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      set_src(1, 1'b1, 8'h10, 1'b0);
      tick();
      for (int w = 0; w < 2; w++) begin
         set_src(1, 1'b1, 8'(8'h10 + w), 1'b0);
         #1;
         checks++; if (grant_id !== 2'd1 || s_data !== 8'(8'h10 + w)) begin failures++;
            $display("FAIL rmid_pre w=%0d grant=%0d data=%h exp=1/%h", w, grant_id, s_data,
                     8'(8'h10 + w)); end
         tick();
      end
      set_src(1, 1'b1, 8'h12, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (s_valid !== 1'b0 || busy !== 1'b0) begin failures++;
         $display("FAIL rmid_idle s_valid=%0b busy=%0b exp=0,0", s_valid, busy); end
      checks++; if (dut.rr_ptr_q !== 2'd3 || grant_id !== 2'd0) begin failures++;
         $display("FAIL rmid_ptr rr=%0d grant=%0d exp=3,0", dut.rr_ptr_q, grant_id); end
      tick();
      checks++; if (grant_id !== 2'd1 || busy !== 1'b1 || s_data !== 8'h12 ||
                    req_ready !== 4'b0010) begin failures++;
         $display("FAIL rmid_regrant grant=%0d busy=%0b data=%h ready=%b exp=1/1/12/0010",
                  grant_id, busy, s_data, req_ready); end
      set_src(1, 1'b1, 8'h12, 1'b1);
      tick();
      set_src(1, 1'b0, 8'h00, 1'b0);
      #1;
      checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin failures++;
         $display("FAIL rmid_end busy=%0b rr=%0d exp=0,1", busy, dut.rr_ptr_q); end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      s_ready   = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_burst_cap();
      test_backpressure();
      test_fairness();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
